// File: rtl/modexp_pkg.sv
// Shared types and constants for the square-and-multiply modular exponentiation sequencer.
package modexp_pkg;

    localparam int DEF_WIDTH     = 512;
    localparam int DEF_EXP_WIDTH = 512;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_SQUARE,
        OP_MULT,
        OP_FINAL
    } op_t;

    // Width of the exponent bit index; never narrower than one bit.
    function automatic int idxWidth(int expWidth);
        return (expWidth > 1) ? $clog2(expWidth) : 1;
    endfunction

endpackage

// File: rtl/modexp_sequencer_if.sv
// Handshake and operand bus between the sequencer and the external Montgomery multiplier.
interface modexp_sequencer_if #(
    parameter int WIDTH = 512
);
    logic             mm_start;
    logic [WIDTH+1:0] mm_in_a;
    logic [WIDTH+1:0] mm_in_b;
    logic [WIDTH+1:0] mm_in_m;
    logic [WIDTH-1:0] mm_result;
    logic             mm_done;

    modport master (
        output mm_start, mm_in_a, mm_in_b, mm_in_m,
        input  mm_result, mm_done
    );

    modport slave (
        input  mm_start, mm_in_a, mm_in_b, mm_in_m,
        output mm_result, mm_done
    );
endinterface

// File: rtl/modexp_exp_counter.sv
// Latched exponent with a descending bit index; reports the bit under the index and
// whether the index has reached bit 0.
module modexp_exp_counter
    import modexp_pkg::*;
#(
    parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 dec_i,
    input  logic [EXP_WIDTH-1:0] exp_i,
    output logic                 bit_o,
    output logic                 last_o
);
    localparam int IW = idxWidth(EXP_WIDTH);

    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [IW-1:0]        idx_q, idx_d;

    // Load restarts the scan at the MSB; decrement steps one bit towards the LSB.
    always_comb begin
        exp_d = exp_q;
        idx_d = idx_q;
        if (load_i) begin
            exp_d = exp_i;
            idx_d = IW'(EXP_WIDTH - 1);
        end else if (dec_i) begin
            idx_d = idx_q - 1'b1;
        end
    end

    // Exponent and index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q <= '0;
            idx_q <= '0;
        end else begin
            exp_q <= exp_d;
            idx_q <= idx_d;
        end
    end

    assign bit_o  = exp_q[idx_q];
    assign last_o = (idx_q == '0);

endmodule

// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply controller computing X^E mod M through an external
// Montgomery multiplier. Accumulator starts at R mod M (Montgomery one); a final
// multiplication by 1 converts the result back to the normal domain.
// Optional build macro MODEXP_SKIP_LEADING_ZEROS_EN: scan past leading zero exponent
// bits before issuing the first squaring.
module modexp_sequencer
    import modexp_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]     in_m,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    modexp_sequencer_if.master   mm
);
    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             expLoad, expDec, expBit, expLast;
    logic [WIDTH-1:0] operandB;

    modexp_exp_counter #(.EXP_WIDTH(EXP_WIDTH)) u_expCounter (
        .clk    (clk),
        .rst    (rst),
        .load_i (expLoad),
        .dec_i  (expDec),
        .exp_i  (in_e),
        .bit_o  (expBit),
        .last_o (expLast)
    );

    // Next-state, operation selection and datapath updates for the exponent scan.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        x_d      = x_q;
        m_d      = m_q;
        result_d = result_q;
        expLoad  = 1'b0;
        expDec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = in_x;
                    m_d     = in_m;
                    acc_d   = in_r;
                    op_d    = OP_SQUARE;
                    expLoad = 1'b1;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
                    state_d = ST_SCAN;
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_SCAN: begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
                if (expBit) begin
                    op_d    = OP_SQUARE;
                    state_d = ST_ISSUE;
                end else if (expLast) begin
                    op_d    = OP_FINAL;
                    state_d = ST_ISSUE;
                end else begin
                    expDec = 1'b1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mm.mm_done) begin
                    acc_d   = mm.mm_result;
                    state_d = ST_ISSUE;
                    case (op_q)
                        OP_SQUARE: begin
                            if (expBit) begin
                                op_d = OP_MULT;
                            end else if (expLast) begin
                                op_d = OP_FINAL;
                            end else begin
                                expDec = 1'b1;
                                op_d   = OP_SQUARE;
                            end
                        end
                        OP_MULT: begin
                            if (expLast) begin
                                op_d = OP_FINAL;
                            end else begin
                                expDec = 1'b1;
                                op_d   = OP_SQUARE;
                            end
                        end
                        default: begin
                            result_d = mm.mm_result;
                            state_d  = ST_DONE;
                        end
                    endcase
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; rst aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_SQUARE;
            acc_q    <= '0;
            x_q      <= '0;
            m_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            m_q      <= m_d;
            result_q <= result_d;
        end
    end

    // Second multiplier operand follows the current operation.
    always_comb begin
        operandB = acc_q;
        case (op_q)
            OP_MULT:  operandB = x_q;
            OP_FINAL: operandB = WIDTH'(1);
            default:  operandB = acc_q;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign result      = result_q;
    assign mm.mm_start = (state_q == ST_ISSUE);
    assign mm.mm_in_a  = {2'b00, acc_q};
    assign mm.mm_in_b  = {2'b00, operandB};
    assign mm.mm_in_m  = {2'b00, m_q};

endmodule

// File: tb/tb_modexp_sequencer.sv
// Bench for modexp_sequencer with WIDTH=8, EXP_WIDTH=4, M=13 and a behavioural Montgomery
// multiplier of configurable latency. Expected results come from a plain normal-domain
// modular exponentiation and a latency formula, queued at stimulus time.
module tb_modexp_sequencer;

    localparam int W    = 8;
    localparam int EW   = 4;
    localparam int MOD  = 13;
    // 2^8 mod 13 = 9 and 9*3 = 27 = 1 mod 13, so R^-1 mod 13 = 3.
    localparam int RINV = 3;

    typedef struct {
        int res;
        int lat;
        int pulses;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  in_x = 8'd5;
    logic [W-1:0]  in_r = 8'd9;
    logic [EW-1:0] in_e = 4'd0;
    logic [W-1:0]  in_m = 8'd13;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    modexp_sequencer_if #(.WIDTH(W)) mmIf ();

    modexp_sequencer #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in_x   (in_x),
        .in_r   (in_r),
        .in_e   (in_e),
        .in_m   (in_m),
        .busy   (busy),
        .done   (done),
        .result (result),
        .mm     (mmIf.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: latches operands on mm_start, answers mm_lat cycles later,
    // and notes any operand change while a multiplication is in flight.
    int           mmLat = 3;
    int           mmCnt = 0;
    logic [W+1:0] aLat = '0;
    logic [W+1:0] bLat = '0;
    logic [W+1:0] mLat = 10'd1;
    int           stabErr = 0;
    int           startPulses = 0;
    int           donePulses = 0;

    always @(posedge clk) begin
        if (rst) begin
            mmCnt <= 0;
        end else begin
            if (mmCnt > 0) begin
                if (mmIf.mm_in_a !== aLat || mmIf.mm_in_b !== bLat || mmIf.mm_in_m !== mLat)
                    stabErr <= stabErr + 1;
                mmCnt <= mmCnt - 1;
            end
            if (mmIf.mm_start === 1'b1) begin
                aLat        <= mmIf.mm_in_a;
                bLat        <= mmIf.mm_in_b;
                mLat        <= mmIf.mm_in_m;
                mmCnt       <= mmLat;
                startPulses <= startPulses + 1;
            end
            if (done === 1'b1) donePulses <= donePulses + 1;
        end
    end

    assign mmIf.mm_done   = (mmCnt == 1);
    assign mmIf.mm_result = W'((int'(aLat) * int'(bLat) * RINV) % int'(mLat));

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   c0 = 0;
    int   pulses0 = 0;
    int   dones0 = 0;

    function automatic int modPow(int x, int e, int m);
        int r;
        r = 1 % m;
        for (int i = EW - 1; i >= 0; i--) begin
            r = (r * r) % m;
            if (e[i]) r = (r * x) % m;
        end
        return r;
    endfunction

    function automatic void timing(int e, int lat, output int doneCyc, output int pulses);
        int msb;
        int squares;
        msb = -1;
        for (int i = 0; i < EW; i++) if (e[i]) msb = i;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        squares = msb + 1;
`else
        squares = EW;
`endif
        pulses = squares + $countones(e[EW-1:0]) + 1;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        if (msb < 0) doneCyc = EW + 1 + (lat + 1);
        else         doneCyc = (EW - 1 - msb) + 2 + pulses * (lat + 1);
`else
        doneCyc = 1 + pulses * (lat + 1);
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Drives a one-cycle start and queues the expected outcome.
    task automatic applyStimulus(input logic [W-1:0] xm, input int xNorm, input logic [EW-1:0] e);
        exp_t ex;
        @(negedge clk);
        in_x    = xm;
        in_e    = e;
        start   = 1'b1;
        c0      = cyc;
        pulses0 = startPulses;
        dones0  = donePulses;
        ex.res  = modPow(xNorm, int'(e), MOD);
        timing(int'(e), mmLat, ex.lat, ex.pulses);
        sb.push_back(ex);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done, then pops the scoreboard and compares.
    task automatic checkOutput(input string tag);
        exp_t ex;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            ex = sb.pop_front();
            if (seen) begin
                check({tag, "_result"}, 64'(result), 64'(ex.res));
                check({tag, "_latency"}, 64'(cyc - c0), 64'(ex.lat));
                check({tag, "_pulses"}, 64'(startPulses - pulses0), 64'(ex.pulses));
                @(negedge clk);
                check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
            end
        end
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mm_start", 64'(mmIf.mm_start), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_mm_in_a", 64'(mmIf.mm_in_a), 64'd0);
        check("rst_mm_in_b", 64'(mmIf.mm_in_b), 64'd0);
        check("rst_mm_in_m", 64'(mmIf.mm_in_m), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed exponents: mixed bits, zero, all ones.
        applyStimulus(8'd5, 2, 4'b0101);
        checkOutput("e0101");
        applyStimulus(8'd5, 2, 4'b0000);
        checkOutput("e0000");
        applyStimulus(8'd5, 2, 4'b1111);
        checkOutput("e1111");

        // Start while busy must be ignored, operands untouched.
        applyStimulus(8'd5, 2, 4'b0101);
        while (cyc - c0 < 10) @(negedge clk);
        in_x  = 8'd7;
        in_e  = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_x  = 8'd5;
        checkOutput("restart");
        repeat (40) @(negedge clk);
        check("restart_single_done", 64'(donePulses - dones0), 64'd1);
        check("restart_idle", 64'(busy), 64'd0);

        // Reset in the middle of an operation.
        applyStimulus(8'd5, 2, 4'b0101);
        while (cyc - c0 < 12) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_mm_start", 64'(mmIf.mm_start), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_mm_in_a", 64'(mmIf.mm_in_a), 64'd0);
        repeat (40) @(negedge clk);
        check("midrst_no_done", 64'(donePulses - dones0), 64'd0);
        applyStimulus(8'd5, 2, 4'b0101);
        checkOutput("after_rst");

        // Stalled multiplier: operands must hold through each multiplication.
        repeat (2) @(negedge clk);
        mmLat = 20;
        applyStimulus(8'd5, 2, 4'b0101);
        checkOutput("stall");
        check("stall_operand_stable", 64'(stabErr), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modexp_sequencer.md
# modexp_sequencer

Left-to-right square-and-multiply controller that computes X^E mod M by sequencing a single external Montgomery multiplier (514-bit operand inputs, 512-bit result, start/done handshake). It owns the accumulator, exponent scan and operand muxing. It sits between the top-level register interface and the multiplier, and is the only driver of the multiplier's inputs.

## Interface
- WIDTH, 512, modulus/result width; multiplier operand width is WIDTH+2
- EXP_WIDTH, 512, exponent width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; also resets the attached multiplier
- start  in  1  request; sampled only in IDLE
- in_x  in  WIDTH  base in Montgomery form (X·R mod M)
- in_r  in  WIDTH  R mod M, with R = 2^WIDTH
- in_e  in  EXP_WIDTH  exponent
- in_m  in  WIDTH  odd modulus
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; result valid from this cycle until next accepted start
- result  out  WIDTH  X^E mod M, normal domain
- mm_start  out  1  one-cycle pulse to multiplier
- mm_in_a, mm_in_b, mm_in_m  out  WIDTH+2  multiplier operands, zero-extended
- mm_result  in  WIDTH  multiplier output
- mm_done  in  1  multiplier completion pulse; mm_result valid that cycle

## Operation
- Start in IDLE: latch in_x, in_r, in_e, in_m; accumulator A <= in_r; bit index i <= EXP_WIDTH-1; op <= SQUARE.
- Ops: SQUARE: a=A, b=A. MULT: a=A, b=X. FINAL: a=A, b=1. mm_in_m = M always.
- States: IDLE, SCAN (macro only), ISSUE, WAIT, DONE.
- ISSUE: mm_start=1 for one cycle -> WAIT.
- WAIT: hold on no mm_done. On mm_done: A <= mm_result, then
  - after SQUARE: if E[i]=1, op=MULT; else if i=0, op=FINAL; else i--, op=SQUARE; -> ISSUE.
  - after MULT: if i=0, op=FINAL; else i--, op=SQUARE; -> ISSUE.
  - after FINAL: result <= mm_result -> DONE.
- DONE: done=1 -> IDLE.
- Op count N = EXP_WIDTH squares + popcount(E) mults + 1 final (without macro).
- E=0: result = 1 mod M (i.e. 1 for M>1).
- Operands mm_in_* must be held stable from the ISSUE cycle through the mm_done cycle; they change only in WAIT on mm_done.
- start while busy: ignored; latched operands are untouched.
- mm_done outside WAIT: ignored.

## Timing
- Reset: state IDLE; busy=0, done=0, mm_start=0, result=0, mm_in_*=0, A=0.
- Reset mid-operation: abort within the same cycle edge; no done pulse; the multiplier is reset by the same rst.
- L = cycles from mm_start to mm_done. Each op costs L+1 cycles.
- Without macro: start at cycle 0, first ISSUE at cycle 1, done at cycle 1+N(L+1).
- With macro: k leading zeros; SCAN takes k+1 cycles; done at cycle k+2+N(L+1). For E=0, done at EXP_WIDTH+1+(L+1).

## Configuration
- MODEXP_SKIP_LEADING_ZEROS_EN defined: from IDLE go to SCAN. SCAN tests one bit of E per cycle, starting at the MSB.
  - E[i]=0 and i>0: i--, stay in SCAN.
  - E[i]=1: op=SQUARE -> ISSUE.
  - All bits zero: op=FINAL -> ISSUE.
  - Skipped squarings are omitted; N shrinks by k.
- Undefined: no SCAN state; all EXP_WIDTH squarings are issued.
- Result is identical either way; only latency differs.

## Structure
- Package modexp_pkg: state enum, op enum (OP_SQUARE, OP_MULT, OP_FINAL), default WIDTH/EXP_WIDTH constants, index width $clog2(EXP_WIDTH).
- Sub-module modexp_exp_counter: latched exponent, bit index, current-bit and last-bit flags, decrement enable.
- Multiplier is instantiated at the top level, not inside this block.

## Test plan
Bench setup: WIDTH=8, EXP_WIDTH=4, behavioural Montgomery multiplier with L=3, M=13, R mod M=9, in_x=5 (X=2).
- E=4'b0101 -> result=6, done at cycle 29 (macro off) / 27 (macro on); exactly 7 / 6 mm_start pulses.
- E=0 -> result=1; 5 mm_start pulses (macro off); 1 pulse with done at cycle 9 (macro on).
- E=4'b1111 -> result=8; 9 mm_start pulses (macro off).
- start pulsed again at cycle 10 of an E=0101 run -> ignored; single done, result=6.
- rst asserted at cycle 12 of a run -> next cycle busy=0, mm_start=0, result=0; no done. A new start then completes normally.
- Stall multiplier (L=20) and check mm_in_a/b/m stable between mm_start and mm_done -> result=6 with no assertion failures.
